// File: rtl/simple_st0_pkg.sv
// Shared types and sizes for the stage-0 pass sequencer.
// State encoding is fixed so probes and dumps stay readable across revisions.
package simple_st0_pkg;

    localparam int TAPS_DEF   = 6;
    localparam int PHASES_DEF = 4;
    localparam int ADDR_W     = 4;
    localparam int PHASE_W    = 2;
    localparam int LCNT_W     = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_FINISH = 3'd3,
        S_UPDATE = 3'd4
    } state_e;

endpackage

// File: rtl/simple_st0_tap_counter.sv
// Tap address / phase counter pair with modulo wrap and synchronous clear.
// Clear has priority over both increments.
module simple_st0_tap_counter
    import simple_st0_pkg::*;
#(
    parameter int TAPS   = TAPS_DEF,
    parameter int PHASES = PHASES_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               inc_i,
    input  logic               phase_inc_i,
    output logic [ADDR_W-1:0]  addr_o,
    output logic [PHASE_W-1:0] phase_o,
    output logic               addr_last_o,
    output logic               phase_last_o
);

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [PHASE_W-1:0] phase_q, phase_d;

    assign addr_last_o  = (addr_q == ADDR_W'(TAPS - 1));
    assign phase_last_o = (phase_q == PHASE_W'(PHASES - 1));
    assign addr_o       = addr_q;
    assign phase_o      = phase_q;

    always_comb begin
        addr_d  = addr_q;
        phase_d = phase_q;
        if (clr_i) begin
            addr_d  = '0;
            phase_d = '0;
        end else begin
            if (inc_i) begin
                addr_d = addr_last_o ? '0 : addr_q + 1'b1;
            end
            if (phase_inc_i) begin
                phase_d = phase_last_o ? '0 : phase_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            phase_q <= '0;
        end else begin
            addr_q  <= addr_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/simple_st0_stage_sequencer.sv
// Stage-0 pass sequencer: LOAD, per-phase RUN sweeps, optional error UPDATE.
// Drives the stage-0 error FIFO controls and the shared tap memory strobes.
module simple_st0_stage_sequencer
    import simple_st0_pkg::*;
#(
    parameter int TAPS   = TAPS_DEF,
    parameter int PHASES = PHASES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               input_stage_cfg,
    input  logic [LCNT_W-1:0]  load_length,
    input  logic               error_update_mode,
    input  logic               data_vld,
    output logic               data_rdy,
    output logic [ADDR_W-1:0]  tap_address,
    output logic [PHASE_W-1:0] tap_phase,
    output logic               tap_rd_en,
    output logic               tap_wr_en,
    output logic               read_finish,
    output logic               state_finish,
    output logic               input_stage,
    output logic               busy,
    output logic               done
);

    state_e              state_q;
    logic [LCNT_W-1:0]   load_cnt_q;
    logic                rd_en_q;
    logic                wr_en_q;
    logic                rf_q;
    logic                sf_q;
    logic                in_stage_q;
    logic                busy_q;
    logic                done_q;

    logic                beat_d;
    logic                advance_d;
    logic                addr_inc_d;
    logic                cnt_clr_d;
    logic                addr_last;
    logic                phase_last;

    assign data_rdy   = (state_q == S_RUN);
    assign beat_d     = data_rdy & data_vld;
    assign advance_d  = ((state_q == S_FINISH) & ~error_update_mode)
                      | ((state_q == S_UPDATE) & addr_last);
    assign addr_inc_d = beat_d | (state_q == S_UPDATE);
    assign cnt_clr_d  = abort | ((state_q == S_IDLE) & start);

    simple_st0_tap_counter #(
        .TAPS   (TAPS),
        .PHASES (PHASES)
    ) u_cnt (
        .clk_i        (clk),
        .rst_ni       (reset),
        .clr_i        (cnt_clr_d),
        .inc_i        (addr_inc_d),
        .phase_inc_i  (advance_d),
        .addr_o       (tap_address),
        .phase_o      (tap_phase),
        .addr_last_o  (addr_last),
        .phase_last_o (phase_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            load_cnt_q <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            rf_q       <= 1'b0;
            sf_q       <= 1'b0;
            in_stage_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (abort) begin
            state_q    <= S_IDLE;
            load_cnt_q <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            rf_q       <= 1'b0;
            sf_q       <= 1'b0;
            in_stage_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            rf_q    <= 1'b0;
            sf_q    <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_LOAD;
                        load_cnt_q <= load_length;
                        in_stage_q <= input_stage_cfg;
                        rd_en_q    <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (load_cnt_q == '0) begin
                        state_q <= S_RUN;
                    end else begin
                        load_cnt_q <= load_cnt_q - 1'b1;
                        rd_en_q    <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (beat_d) begin
                        rd_en_q <= 1'b1;
                        if (addr_last) begin
                            state_q <= S_FINISH;
                            rf_q    <= 1'b1;
                            sf_q    <= 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    if (error_update_mode) begin
                        state_q <= S_UPDATE;
                        wr_en_q <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    if (!addr_last) begin
                        wr_en_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // Phase advance is shared by the FINISH and UPDATE exits.
            if (advance_d) begin
                if (phase_last) begin
                    state_q    <= S_IDLE;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    in_stage_q <= 1'b0;
                end else begin
                    state_q <= S_RUN;
                end
            end
        end
    end

    assign tap_rd_en    = rd_en_q;
    assign tap_wr_en    = wr_en_q;
    assign read_finish  = rf_q;
    assign state_finish = sf_q;
    assign input_stage  = in_stage_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_simple_st0_stage_sequencer.sv
// Bench for the stage-0 pass sequencer: cycle model plus directed passes.
// Inputs change on the falling edge; outputs are checked 1ns after rising.
module tb_simple_st0_stage_sequencer;

    localparam int TAPS   = 6;
    localparam int PHASES = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       cfg = 1'b0;
    logic [2:0] ll = 3'd0;
    logic       err = 1'b0;
    logic       vld = 1'b0;

    logic       data_rdy;
    logic [3:0] tap_address;
    logic [1:0] tap_phase;
    logic       tap_rd_en;
    logic       tap_wr_en;
    logic       read_finish;
    logic       state_finish;
    logic       input_stage;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    simple_st0_stage_sequencer #(
        .TAPS   (TAPS),
        .PHASES (PHASES)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .abort             (abort),
        .input_stage_cfg   (cfg),
        .load_length       (ll),
        .error_update_mode (err),
        .data_vld          (vld),
        .data_rdy          (data_rdy),
        .tap_address       (tap_address),
        .tap_phase         (tap_phase),
        .tap_rd_en         (tap_rd_en),
        .tap_wr_en         (tap_wr_en),
        .read_finish       (read_finish),
        .state_finish      (state_finish),
        .input_stage       (input_stage),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: pass progress kept as remaining-cycle counts.
    bit m_busy, m_run, m_fin, m_rd, m_wr, m_rf, m_sf, m_done, m_ins;
    int m_load, m_upd, m_addr, m_phase;

    task automatic m_zero();
        m_busy = 0; m_run = 0; m_fin = 0; m_rd = 0; m_wr = 0;
        m_rf = 0; m_sf = 0; m_done = 0; m_ins = 0;
        m_load = 0; m_upd = 0; m_addr = 0; m_phase = 0;
    endtask

    task automatic m_advance();
        if (m_phase == PHASES - 1) begin
            m_phase = 0;
            m_busy = 0;
            m_done = 1;
            m_ins = 0;
        end else begin
            m_phase++;
            m_run = 1;
        end
    endtask

    task automatic m_step();
        m_rd = 0; m_wr = 0; m_rf = 0; m_sf = 0; m_done = 0;
        if (abort) begin
            m_zero();
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1;
                m_load = int'(ll) + 1;
                m_ins = cfg;
                m_rd = 1;
                m_addr = 0;
                m_phase = 0;
            end
        end else if (m_load > 0) begin
            m_load--;
            if (m_load == 0) m_run = 1;
            else m_rd = 1;
        end else if (m_run) begin
            if (vld) begin
                m_rd = 1;
                m_addr++;
                if (m_addr == TAPS) begin
                    m_addr = 0;
                    m_run = 0;
                    m_fin = 1;
                    m_rf = 1;
                    m_sf = 1;
                end
            end
        end else if (m_fin) begin
            m_fin = 0;
            if (err) begin
                m_upd = TAPS;
                m_wr = 1;
            end else begin
                m_advance();
            end
        end else if (m_upd > 0) begin
            m_addr = (m_addr + 1) % TAPS;
            m_upd--;
            if (m_upd == 0) m_advance();
            else m_wr = 1;
        end
    endtask

    initial m_zero();

    always @(posedge clk) begin
        if (!reset) m_zero();
        else m_step();
        #1;
        if (chk_on) begin
            chk("data_rdy", data_rdy, m_run);
            chk("tap_address", tap_address, m_addr);
            chk("tap_phase", tap_phase, m_phase);
            chk("tap_rd_en", tap_rd_en, m_rd);
            chk("tap_wr_en", tap_wr_en, m_wr);
            chk("read_finish", read_finish, m_rf);
            chk("state_finish", state_finish, m_sf);
            chk("input_stage", input_stage, m_ins);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
        end
    end

    task automatic run_pass(input logic [2:0] l, input logic c,
                            input logic [3:0] umask, input bit toggle,
                            input int again_at,
                            output int t_rdy, output int t_done,
                            output int n_rf, output int n_sf,
                            output int n_wr, output int wr_sum,
                            output int n_ins_bad, output int beats_rf1);
        int beats;
        ll = l; cfg = c; start = 1'b1;
        t_rdy = -1; t_done = -1; n_rf = 0; n_sf = 0; n_wr = 0;
        wr_sum = 0; n_ins_bad = 0; beats_rf1 = -1; beats = 0;
        for (int k = 1; k <= 300 && t_done < 0; k++) begin
            @(negedge clk);
            start = (k == again_at);
            vld = toggle ? k[0] : 1'b1;
            if (data_rdy && t_rdy < 0) t_rdy = k;
            if (read_finish) begin
                n_rf++;
                if (beats_rf1 < 0) beats_rf1 = beats;
            end
            if (data_rdy && vld) beats++;
            if (state_finish && n_sf < 4) begin
                err = umask[n_sf];
                n_sf++;
            end else begin
                err = 1'b0;
            end
            if (tap_wr_en) begin
                n_wr++;
                wr_sum += int'(tap_address);
            end
            if (c && busy && !input_stage) n_ins_bad++;
            if (done) t_done = k;
        end
        vld = 1'b0; err = 1'b0; start = 1'b0; cfg = 1'b0;
        if (t_done < 0) chk("done_timeout", 0, 1);
    endtask

    int t_rdy, t_done, n_rf, n_sf, n_wr, wr_sum, n_ib, b_rf1, cnt;
    bit found;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", data_rdy, 0);
        chk("rst_addr", tap_address, 0);
        chk("rst_phase", tap_phase, 0);
        chk("rst_ins", input_stage, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        chk_on = 1'b1;
        repeat (2) @(negedge clk);

        // Continuous data, no update, extra start while busy.
        run_pass(3'd2, 1'b0, 4'b0000, 1'b0, 10,
                 t_rdy, t_done, n_rf, n_sf, n_wr, wr_sum, n_ib, b_rf1);
        chk("A_rdy_lat", t_rdy, 4);
        chk("A_done_cyc", t_done, 32);
        chk("A_n_rf", n_rf, 4);
        chk("A_n_sf", n_sf, 4);
        chk("A_n_wr", n_wr, 0);
        chk("A_beats_rf1", b_rf1, 6);
        repeat (2) @(negedge clk);

        // Error update after phase 1, input stage latched.
        run_pass(3'd2, 1'b1, 4'b0010, 1'b0, 0,
                 t_rdy, t_done, n_rf, n_sf, n_wr, wr_sum, n_ib, b_rf1);
        chk("B_done_cyc", t_done, 38);
        chk("B_n_wr", n_wr, 6);
        chk("B_wr_sum", wr_sum, 15);
        chk("B_n_rf", n_rf, 4);
        chk("B_ins_held", n_ib, 0);
        @(negedge clk);
        chk("B_ins_clear", input_stage, 0);
        repeat (2) @(negedge clk);

        // Toggling data_vld: beats only on odd cycles.
        run_pass(3'd0, 1'b0, 4'b0000, 1'b1, 0,
                 t_rdy, t_done, n_rf, n_sf, n_wr, wr_sum, n_ib, b_rf1);
        chk("C_rdy_lat", t_rdy, 2);
        chk("C_beats_rf1", b_rf1, 6);
        chk("C_done_cyc", t_done, 51);
        repeat (2) @(negedge clk);

        // Abort in UPDATE at address 2.
        ll = 3'd1; cfg = 1'b1; err = 1'b1; vld = 1'b1; start = 1'b1;
        found = 1'b0;
        for (int k = 1; k <= 100 && !found; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (tap_wr_en && tap_address == 4'd2) begin
                found = 1'b1;
                chk("D_hit_cyc", k, 12);
            end
        end
        if (!found) chk("D_update_timeout", 0, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; err = 1'b0; vld = 1'b0; cfg = 1'b0;
        chk("D_busy", busy, 0);
        chk("D_wr", tap_wr_en, 0);
        chk("D_addr", tap_address, 0);
        chk("D_ins", input_stage, 0);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("D_no_done", cnt, 0);

        // start with abort in IDLE.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("E_busy0", busy, 0);
        @(negedge clk);
        chk("E_busy1", busy, 0);

        // Reset mid-RUN at tap_address 3.
        ll = 3'd0; cfg = 1'b1; vld = 1'b1; start = 1'b1;
        found = 1'b0;
        for (int k = 1; k <= 50 && !found; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (data_rdy && tap_address == 4'd3) found = 1'b1;
        end
        if (!found) chk("F_run_timeout", 0, 1);
        reset = 1'b0;
        #1;
        chk("F_rdy", data_rdy, 0);
        chk("F_addr", tap_address, 0);
        chk("F_busy", busy, 0);
        chk("F_rd", tap_rd_en, 0);
        chk("F_ins", input_stage, 0);
        @(negedge clk);
        vld = 1'b0; cfg = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("F_idle_busy", busy, 0);
        chk("F_idle_rdy", data_rdy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simple_st0_stage_sequencer.md
# simple_st0_stage_sequencer

Stage-0 pass sequencer for the simple network. It drives the control inputs of the stage-0 error FIFO controller: `state_finish`, `read_finish` and `input_stage`. It also sequences the shared tap memory through load, forward-run and error-update sweeps. It sits between the top-level stage scheduler (`start`/`done`) and the stage-0 datapath, and it gates forward data with a ready/valid handshake.

## Interface
Parameters:
- TAPS, 6, taps per sweep; tap_address runs 0..TAPS-1.
- PHASES, 4, phases per pass; tap_phase runs 0..PHASES-1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a pass; ignored unless IDLE.
- abort  in  1  return to IDLE next cycle from any state.
- input_stage_cfg  in  1  this stage is the network input stage.
- load_length  in  3  LOAD duration minus 1, sampled on start.
- error_update_mode  in  1  error FIFO non-empty; sampled in FINISH.
- data_vld  in  1  forward data valid.
- data_rdy  out  1  forward data ready; combinational, equals (state==RUN).
- tap_address  out  4  tap memory address.
- tap_phase  out  2  current phase.
- tap_rd_en  out  1  tap memory read strobe.
- tap_wr_en  out  1  tap memory write strobe (error update).
- read_finish  out  1  pulse: last tap read of a RUN sweep.
- state_finish  out  1  pulse: sweep complete (FINISH state).
- input_stage  out  1  registered copy of input_stage_cfg, held for the pass.
- busy  out  1  state != IDLE.
- done  out  1  pulse: pass complete.

## Operation
- States: IDLE, LOAD, RUN, FINISH, UPDATE.
- IDLE → LOAD on start. On the same edge: latch load_length into load_cnt, latch input_stage_cfg into input_stage, clear tap_phase and tap_address.
- LOAD: tap_rd_en=1, tap_address=0. load_cnt decrements each cycle; at load_cnt==0 → RUN. LOAD lasts load_length+1 cycles.
- RUN: each data_vld&data_rdy beat asserts tap_rd_en and increments tap_address.
  - On the beat accepted at tap_address==TAPS-1: tap_address wraps to 0, read_finish pulses next cycle, state → FINISH.
  - No beat means no advance. No timeout.
- FINISH (one cycle): state_finish=1; sample error_update_mode.
  - Sampled 1 → UPDATE.
  - Sampled 0 → advance the phase.
- UPDATE: tap_wr_en=1 every cycle, tap_address 0..TAPS-1, no stall. After address TAPS-1 → advance the phase.
- Phase advance:
  - tap_phase<PHASES-1: tap_phase+1, → RUN.
  - tap_phase==PHASES-1: tap_phase→0, done pulse, → IDLE.
- abort has priority over all transitions. It forces IDLE and clears counters, strobes and pulses next edge. input_stage is cleared.
- Widths: tap_address wraps modulo TAPS, never reaching TAPS. tap_phase wraps modulo PHASES. load_cnt is 3 bits.

## Timing
- Reset (async assert, sync deassert by the top): state=IDLE; all outputs 0, including data_rdy, tap_address, tap_phase, input_stage and busy.
- All outputs are registered except data_rdy.
- Latency from start (cycle 0) to first data_rdy=1: load_length+2 cycles.
- read_finish is one cycle after the last RUN beat. state_finish is high in that same cycle, since FINISH is entered on the last-beat edge.
- UPDATE lasts exactly TAPS cycles.
- done is one cycle, on the edge leaving the last FINISH or UPDATE.
- start while busy is ignored.
- start and abort in the same cycle in IDLE: abort wins, stay IDLE.
- data_vld while not RUN: no effect, since data_rdy=0.

## Structure
- Shared package `simple_st0_pkg` holds:
  - the state enum (IDLE=0, LOAD=1, RUN=2, FINISH=3, UPDATE=4; 3 bits);
  - TAPS and PHASES defaults;
  - the tap address and phase widths.
- Single module. The tap address/phase counter pair is a natural sub-module, `simple_st0_tap_counter` (inc, clear, wrap flag).

## Test plan
- Reset mid-RUN (tap_address=3) → all outputs 0 immediately; IDLE after release.
- start, load_length=2, continuous data_vld, error_update_mode=0:
  - LOAD for 3 cycles;
  - 6 beats per phase;
  - read_finish and state_finish once per phase, 4 times total;
  - done 4×(6+1)+3+1 cycles after start.
- Same pass with error_update_mode=1 in phase 1 only → UPDATE after phase 1: 6 tap_wr_en cycles, addresses 0..5; done delayed by 6 cycles.
- data_vld toggled 1/0 → tap_address advances only on handshake beats; read_finish after the 6th beat.
- abort asserted in UPDATE at tap_address=2 → next cycle IDLE, tap_wr_en=0, busy=0, no done pulse.
- start while busy, and start with abort in IDLE → both ignored; input_stage_cfg=1 latched as input_stage=1 for the whole pass.
